// File: rtl/write_only_register.sv
// -----------------------------------------------------------------------------
// write_only_register
//
// Processor-facing write-only register with a small queue toward I/O logic.
// A qualified write merges data into a shadow register under a bit mask.
// The merged value is also queued for the I/O side, which drains the queue
// one entry at a time with IO_Ack.
//
// Optional build macro:
//   WOR_READBACK_EN - when defined, Sys_RdData returns the shadow register.
//                     When undefined, Sys_RdData is tied to zero.
//
// Ports:
//   Clock           - single clock for both the processor side and the I/O side
//   Reset           - asynchronous, active-high reset
//   Sys_RegSelect   - register addressed by the processor this cycle
//   Sys_WrEn        - write strobe, qualified by Sys_RegSelect
//   Sys_WrData      - write data
//   Sys_WrMask      - per-bit merge mask (1 = take new data, 0 = keep shadow bit)
//   Sys_StatusClear - clears the sticky overflow flag
//   Sys_RdData      - shadow readback (zero unless WOR_READBACK_EN)
//   Sys_Full        - queue holds FIFO_DEPTH entries
//   Sys_Overflow    - sticky flag, set when a write could not be queued
//   Sys_Level       - current queue occupancy
//   IO_Data         - head entry, or the last delivered value when empty
//   IO_Valid        - IO_Data holds an undelivered entry
//   IO_Ack          - I/O logic consumes the head entry
// -----------------------------------------------------------------------------
module write_only_register #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Sys_RegSelect,
    input  logic                          Sys_WrEn,
    input  logic [DATA_WIDTH-1:0]         Sys_WrData,
    input  logic [DATA_WIDTH-1:0]         Sys_WrMask,
    input  logic                          Sys_StatusClear,
    output logic [DATA_WIDTH-1:0]         Sys_RdData,
    output logic                          Sys_Full,
    output logic                          Sys_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Sys_Level,
    output logic [DATA_WIDTH-1:0]         IO_Data,
    output logic                          IO_Valid,
    input  logic                          IO_Ack
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] shadow;
    logic [DATA_WIDTH-1:0] last_popped;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic                  write;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  empty;

    // Full/empty come from the occupancy count, because the pointers are
    // equal both when the queue is empty and when it is full.
    assign write  = Sys_RegSelect & Sys_WrEn;
    assign empty  = (level == '0);
    assign full   = (level == DEPTH_LVL);
    assign pop    = IO_Ack & ~empty;
    // A pop in the same cycle frees the slot, so a write to a full queue
    // is still accepted.
    assign push   = write & (~full | pop);
    assign merged = (shadow & ~Sys_WrMask) | (Sys_WrData & Sys_WrMask);

    // The shadow register always takes the merge, even when the write is dropped.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shadow <= RESET_VALUE;
        end else if (write) begin
            shadow <= merged;
        end
    end

    // The storage array needs no reset: the pointers and the level decide
    // which entries are live.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= merged;
        end
    end

    // The pointers wrap naturally because FIFO_DEPTH is a power of two.
    // On a pop, the head is kept in last_popped so IO_Data holds it once
    // the queue drains.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            last_popped <= RESET_VALUE;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                last_popped <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // If a new overflow and a clear arrive together, the set wins.
            if (write && full && !pop) begin
                overflow <= 1'b1;
            end else if (Sys_StatusClear) begin
                overflow <= 1'b0;
            end
        end
    end

    assign Sys_Full     = full;
    assign Sys_Overflow = overflow;
    assign Sys_Level    = level;
    assign IO_Valid     = ~empty;
    assign IO_Data      = empty ? last_popped : mem[rd_ptr];

`ifdef WOR_READBACK_EN
    assign Sys_RdData = shadow;
`else
    assign Sys_RdData = '0;
`endif

endmodule

// File: tb/tb_write_only_register.sv
// -----------------------------------------------------------------------------
// tb_write_only_register
//
// Self-checking bench for write_only_register with default parameters.
// A queue-based scoreboard holds the values expected on IO_Data in delivery
// order. A write pushes its merged value into the queue, and an IO_Ack pops
// the head. Shadow, overflow and last-delivered state are modelled alongside.
// The bench honours WOR_READBACK_EN when it checks Sys_RdData.
// -----------------------------------------------------------------------------
module tb_write_only_register;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          Clock;
    logic          Reset;
    logic          Sys_RegSelect;
    logic          Sys_WrEn;
    logic [DW-1:0] Sys_WrData;
    logic [DW-1:0] Sys_WrMask;
    logic          Sys_StatusClear;
    logic [DW-1:0] Sys_RdData;
    logic          Sys_Full;
    logic          Sys_Overflow;
    logic [2:0]    Sys_Level;
    logic [DW-1:0] IO_Data;
    logic          IO_Valid;
    logic          IO_Ack;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] expQ[$];
    logic [DW-1:0] expShadow;
    logic [DW-1:0] expLast;
    logic          expOverflow;

    write_only_register #(
        .DATA_WIDTH (DW),
        .RESET_VALUE('0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Sys_RegSelect  (Sys_RegSelect),
        .Sys_WrEn       (Sys_WrEn),
        .Sys_WrData     (Sys_WrData),
        .Sys_WrMask     (Sys_WrMask),
        .Sys_StatusClear(Sys_StatusClear),
        .Sys_RdData     (Sys_RdData),
        .Sys_Full       (Sys_Full),
        .Sys_Overflow   (Sys_Overflow),
        .Sys_Level      (Sys_Level),
        .IO_Data        (IO_Data),
        .IO_Valid       (IO_Valid),
        .IO_Ack         (IO_Ack)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Safety net so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Compare every output against the model.
    task automatic checkState(input string tag);
        logic [DW-1:0] expData;
        logic [DW-1:0] expRd;
        expData = (expQ.size() != 0) ? expQ[0] : expLast;
`ifdef WOR_READBACK_EN
        expRd = expShadow;
`else
        expRd = '0;
`endif
        checkOutput({tag, ".valid"},    DW'(IO_Valid),     DW'(expQ.size() != 0));
        checkOutput({tag, ".level"},    DW'(Sys_Level),    DW'(expQ.size()));
        checkOutput({tag, ".full"},     DW'(Sys_Full),     DW'(expQ.size() == DEPTH));
        checkOutput({tag, ".overflow"}, DW'(Sys_Overflow), DW'(expOverflow));
        checkOutput({tag, ".data"},     IO_Data,           expData);
        checkOutput({tag, ".rdata"},    Sys_RdData,        expRd);
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then update the model.
    // The model uses the state from before the edge.
    task automatic applyStimulus(input logic sel, input logic we, input logic [DW-1:0] data,
                                 input logic [DW-1:0] mask, input logic ack, input logic clr);
        logic          wr;
        logic          pop;
        logic          full;
        logic [DW-1:0] merged;
        Sys_RegSelect   = sel;
        Sys_WrEn        = we;
        Sys_WrData      = data;
        Sys_WrMask      = mask;
        IO_Ack          = ack;
        Sys_StatusClear = clr;
        wr     = sel && we;
        pop    = ack && (expQ.size() != 0);
        full   = (expQ.size() == DEPTH);
        merged = (expShadow & ~mask) | (data & mask);
        @(posedge Clock);
        #1;
        if (pop) expLast = expQ.pop_front();
        if (wr) begin
            expShadow = merged;
            if (!full || pop) expQ.push_back(merged);
        end
        if (wr && full && !pop) expOverflow = 1'b1;
        else if (clr)           expOverflow = 1'b0;
        Sys_RegSelect   = 1'b0;
        Sys_WrEn        = 1'b0;
        Sys_WrData      = '0;
        Sys_WrMask      = '0;
        IO_Ack          = 1'b0;
        Sys_StatusClear = 1'b0;
    endtask

    task automatic modelReset();
        expQ.delete();
        expShadow   = '0;
        expLast     = '0;
        expOverflow = 1'b0;
    endtask

    initial begin
        Reset           = 1'b1;
        Sys_RegSelect   = 1'b0;
        Sys_WrEn        = 1'b0;
        Sys_WrData      = '0;
        Sys_WrMask      = '0;
        Sys_StatusClear = 1'b0;
        IO_Ack          = 1'b0;
        modelReset();
        #12;
        checkState("reset");
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        // Basic write, one-cycle latency, then delivery.
        applyStimulus(1, 1, 32'h12345678, 32'hFFFFFFFF, 0, 0);
        checkState("write1");
        checkOutput("write1.literal", IO_Data, 32'h12345678);
        applyStimulus(0, 0, '0, '0, 1, 0);
        checkState("ack1");
        checkOutput("ack1.hold", IO_Data, 32'h12345678);

        // Masked merge against the shadow register.
        applyStimulus(1, 1, 32'hAAAAAAAA, 32'h0000FFFF, 0, 0);
        checkState("merge");
        checkOutput("merge.literal", IO_Data, 32'h1234AAAA);
        applyStimulus(0, 0, '0, '0, 1, 0);
        checkState("merge.ack");

        // An unqualified strobe and an IO_Ack on an empty queue change nothing.
        applyStimulus(0, 1, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0);
        checkState("nosel");
        applyStimulus(1, 0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0);
        checkState("nowen");
        applyStimulus(0, 0, '0, '0, 1, 0);
        checkState("ackempty");

        // Five writes into a depth-4 queue: the last write is dropped.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 1, DW'(i), 32'hFFFFFFFF, 0, 0);
            checkState($sformatf("fill%0d", i));
        end
        checkOutput("fill.ovf", DW'(Sys_Overflow), 32'd1);
        applyStimulus(0, 0, '0, '0, 0, 1);
        checkState("clear");
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("order%0d", i), IO_Data, DW'(i));
            applyStimulus(0, 0, '0, '0, 1, 0);
            checkState($sformatf("drain%0d", i));
        end

        // A full queue with a simultaneous write and ack keeps its level.
        for (int i = 5; i <= 8; i++) applyStimulus(1, 1, DW'(i), 32'hFFFFFFFF, 0, 0);
        checkState("refill");
        applyStimulus(1, 1, 32'd9, 32'hFFFFFFFF, 1, 0);
        checkState("fullpushpop");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, '0, 1, 0);
        checkState("drain9");
        checkOutput("last9", IO_Data, 32'd9);

        // A clear and a new overflow in the same cycle: the set wins.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, DW'(16 + i), 32'hFFFFFFFF, 0, 0);
        applyStimulus(1, 1, 32'd99, 32'hFFFFFFFF, 0, 1);
        checkState("setwins");
        applyStimulus(0, 0, '0, '0, 0, 1);
        checkState("clear2");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, '0, 1, 0);

        // A write on an empty queue with IO_Ack high pushes only.
        applyStimulus(1, 1, 32'h0000BEEF, 32'hFFFFFFFF, 1, 0);
        checkState("emptyack");
        applyStimulus(0, 0, '0, '0, 1, 0);

        // Reset pulsed between edges discards the queued entries immediately.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, DW'(32'hA0 + i), 32'hFFFFFFFF, 0, 0);
        checkState("prereset");
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        checkState("midreset");
        #1;
        Reset = 1'b0;
        applyStimulus(0, 0, '0, '0, 1, 0);
        checkState("postreset");
        applyStimulus(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        checkState("allones");
        checkOutput("allones.literal", IO_Data, 32'hFFFFFFFF);
        applyStimulus(0, 0, '0, '0, 1, 0);
        checkState("allones.ack");

        // Random traffic to exercise pointer wrap with mixed strobes.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
                          DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            checkState($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
